// File: rtl/rpn_stack_core.sv
// RPN calculator stack engine: register-array stack, single-cycle ALU ops
// and a sequential signed shift-add multiplier, with sticky error flags.
module rpn_stack_core #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int SATURATE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd_op,
  input  logic [DATA_W-1:0]          din,
  output logic                       cmd_ready,
  output logic [DATA_W-1:0]          dout,
  output logic                       dval,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic [2:0]                 err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DATA_W);
  localparam int PW = 2 * DATA_W;

  localparam logic [DATA_W-1:0] VMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] VMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] stk [DEPTH];

  logic [PW-1:0]     acc, mcand, addend, acc_nx;
  logic [DATA_W-1:0] mplier;
  logic [SW-1:0]     step;
  logic              last;

  logic op_push, op_pop, op_add, op_mult;
  logic op_sub, op_dup, op_swap, op_clear;
  logic accept, full, empty, lt2;
  logic ovf, unf, rej;

  logic [AW-1:0]     top_i, tos_i, nos_i;
  logic [DATA_W-1:0] tos, nos;
  logic [DATA_W:0]   sum_x;
  logic              alu_ovf, mul_ovf;
  logic [DATA_W-1:0] alu_res, mul_res;

  function automatic logic [DATA_W-1:0] fit(
    input logic              o,
    input logic              neg,
    input logic [DATA_W-1:0] low
  );
    if (o && SATURATE != 0)
      return neg ? VMIN : VMAX;
    return low;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == MUL);
  assign accept    = cmd_valid && cmd_ready;

  assign op_push  = (cmd_op == 3'd0);
  assign op_pop   = (cmd_op == 3'd1);
  assign op_add   = (cmd_op == 3'd2);
  assign op_mult  = (cmd_op == 3'd3);
  assign op_sub   = (cmd_op == 3'd4);
  assign op_dup   = (cmd_op == 3'd5);
  assign op_swap  = (cmd_op == 3'd6);
  assign op_clear = (cmd_op == 3'd7);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign lt2   = (count < CW'(2));

  assign ovf = (op_push || op_dup) && full;
  assign unf = ((op_pop || op_dup) && empty)
            || ((op_add || op_sub || op_mult || op_swap) && lt2);
  assign rej = ovf || unf;

  assign top_i = AW'(count);
  assign tos_i = AW'(count - CW'(1));
  assign nos_i = AW'(count - CW'(2));
  assign tos   = stk[tos_i];
  assign nos   = stk[nos_i];

  assign dval = !empty;
  assign dout = empty ? '0 : tos;

  // Exact result in DATA_W+1 bits; overflow when the top two bits differ
  assign sum_x = op_sub
    ? {nos[DATA_W-1], nos} - {tos[DATA_W-1], tos}
    : {nos[DATA_W-1], nos} + {tos[DATA_W-1], tos};
  assign alu_ovf = sum_x[DATA_W] != sum_x[DATA_W-1];
  assign alu_res = fit(alu_ovf, sum_x[DATA_W], sum_x[DATA_W-1:0]);

  // Multiplier MSB carries weight -2^(DATA_W-1), so its partial is subtracted
  assign last   = (step == SW'(DATA_W - 1));
  assign addend = mplier[0] ? (last ? -mcand : mcand) : '0;
  assign acc_nx = acc + addend;
  assign mul_ovf = !((&acc_nx[PW-1:DATA_W-1])
                  || (~|acc_nx[PW-1:DATA_W-1]));
  assign mul_res = fit(mul_ovf, acc_nx[PW-1], acc_nx[DATA_W-1:0]);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && op_mult && !unf) state_nx = MUL;
      MUL:  if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      err    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      step   <= '0;
    end else if (state == MUL) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + SW'(1);
      if (last) begin
        stk[nos_i] <= mul_res;
        count      <= count - CW'(1);
        if (mul_ovf) err[2] <= 1'b1;
      end
    end else if (accept) begin
      if (op_clear) begin
        count <= '0;
        err   <= '0;
      end else if (rej) begin
        err[0] <= err[0] | ovf;
        err[1] <= err[1] | unf;
      end else begin
        unique case (1'b1)
          op_push: begin
            stk[top_i] <= din;
            count      <= count + CW'(1);
          end
          op_pop: count <= count - CW'(1);
          op_add, op_sub: begin
            stk[nos_i] <= alu_res;
            count      <= count - CW'(1);
            if (alu_ovf) err[2] <= 1'b1;
          end
          op_mult: begin
            acc    <= '0;
            mcand  <= {{DATA_W{nos[DATA_W-1]}}, nos};
            mplier <= tos;
            step   <= '0;
          end
          op_dup: begin
            stk[top_i] <= tos;
            count      <= count + CW'(1);
          end
          op_swap: begin
            stk[tos_i] <= nos;
            stk[nos_i] <= tos;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
